// File: rtl/display_pkg.sv
// Shared types and defaults for the multiplexed hex display scanner.
// Holds the scanner state encoding, default sizing and a width helper.
package display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    localparam int NIBBLE_W          = 4;
    localparam int DISP_NUM_DIGITS   = 4;
    localparam int DISP_CLK_DIV      = 50000;
    localparam int DISP_BLANK_CYCLES = 2;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_slot_timer.sv
// Slot timer: counts clocks within a digit slot and steps the digit index.
// Ports: clk, rst_n, run_i (next cycle is scanning), adv_i (scanning now),
//        cnt_d_o/idx_d_o (next slot position), frame_done_o (registered).
module display_slot_timer
    import display_pkg::*;
#(
    parameter int CLK_DIV    = DISP_CLK_DIV,
    parameter int NUM_DIGITS = DISP_NUM_DIGITS,
    localparam int CNT_W     = cnt_width(CLK_DIV),
    localparam int IDX_W     = cnt_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic [IDX_W-1:0] idx_d_o,
    output logic             frame_done_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_q, frame_d;

    // Counters sit at zero whenever not scanning, so the first
    // scanning cycle is always slot 0 of digit 0.
    always_comb begin
        cnt_d = '0;
        idx_d = '0;
        if (adv_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q;
            end
        end
        frame_d = run_i && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

    assign cnt_d_o      = cnt_d;
    assign idx_d_o      = idx_d;
    assign frame_done_o = frame_q;

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexes a hex value across common-anode digits with blanking,
// frame-aligned value updates and optional leading-zero suppression.
// Ports: clk, rst_n, enable, load, value_in -> hex_digit, digit_sel_n,
//        blank, frame_done (all registered).
module hex_display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DISP_NUM_DIGITS,
    parameter int CLK_DIV      = DISP_CLK_DIV,
    parameter int BLANK_CYCLES = DISP_BLANK_CYCLES,
    parameter int LZ_SUPPRESS  = 1,
    localparam int VAL_W       = NIBBLE_W * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [VAL_W-1:0]      value_in,
    output logic [NIBBLE_W-1:0]   hex_digit,
    output logic [NUM_DIGITS-1:0] digit_sel_n,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int CNT_W = cnt_width(CLK_DIV);
    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    scan_state_e state_q, state_d;

    logic [VAL_W-1:0] disp_q, disp_d;
    logic [VAL_W-1:0] pend_q, pend_d;
    logic             pv_q, pv_d;

    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] idx_d;
    logic             frame_q;

    logic [NIBBLE_W-1:0]   hex_q, hex_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  blank_q, blank_d;

    logic [NUM_DIGITS-1:0] zero_up;
    logic [NIBBLE_W-1:0]   nib_sel;
    logic                  sup_sel;

    display_slot_timer #(
        .CLK_DIV    (CLK_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (state_d == SCAN),
        .adv_i        ((state_q == SCAN) && enable),
        .cnt_d_o      (cnt_d),
        .idx_d_o      (idx_d),
        .frame_done_o (frame_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable)  state_d = SCAN;
            SCAN: if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Display / pending update. The display register only changes at
    // a frame boundary (or while idle), so a frame never mixes values.
    always_comb begin
        disp_d = disp_q;
        pend_d = pend_q;
        pv_d   = pv_q;
        if (state_q == IDLE) begin
            if (load) begin
                disp_d = value_in;
            end
            if (enable) begin
                if (!load && pv_q) begin
                    disp_d = pend_q;
                end
                pv_d = 1'b0;
            end
        end else begin
            if (frame_q) begin
                if (load) begin
                    disp_d = value_in;
                end else if (pv_q) begin
                    disp_d = pend_q;
                end
                pv_d = 1'b0;
            end else if (load) begin
                pend_d = value_in;
                pv_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            pend_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            disp_q <= disp_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
        end
    end

    // zero_up[i] is set when nibbles i..top of the next display value
    // are all zero; that marks digit i as a leading zero.
    always_comb begin
        logic acc;
        acc     = 1'b1;
        zero_up = '0;
        nib_sel = '0;
        sup_sel = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc = acc & (disp_d[i*NIBBLE_W +: NIBBLE_W] == '0);
            zero_up[i] = acc;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib_sel = disp_d[i*NIBBLE_W +: NIBBLE_W];
                sup_sel = (LZ_SUPPRESS != 0) && (i != 0) && zero_up[i];
            end
        end
    end

    // Output logic, computed from next-cycle position so the registered
    // outputs line up with the slot counter.
    always_comb begin
        logic lit;
        hex_d   = '0;
        sel_d   = '1;
        blank_d = 1'b1;
        lit     = 1'b0;
        if (state_d == SCAN) begin
            hex_d = nib_sel;
            lit   = ((BLANK_CYCLES == 0) || (cnt_d >= BLANK_END)) && !sup_sel;
            if (lit) begin
                blank_d = 1'b0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_d == IDX_W'(i)) sel_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q   <= '0;
            sel_q   <= '1;
            blank_q <= 1'b1;
        end else begin
            hex_q   <= hex_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
        end
    end

    assign hex_digit   = hex_q;
    assign digit_sel_n = sel_q;
    assign blank       = blank_q;
    assign frame_done  = frame_q;

endmodule
